spi_flash_loader: RTL and testbench

//  Boot-time sequencer for SPI port 1. After reset it drives the spi engine to issue a

---
 rtl/spi_flash_loader.sv | 207 ++++++++++++++++++++
 tb/tb_spi_flash_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_loader.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_loader
// Description : Boot-time sequencer for SPI port 1. After reset it issues a
//               flash READ (0x03 + 24-bit address), streams LENGTH bytes into
//               cartridge RAM, then hands the SPI engine to the CPU-side
//               peripheral registers. A reload pulse in DONE repeats the load.
// Ports       : raw_clk/reset         - clock, async active-low reset
//               reload                - restart request (honoured in DONE only)
//               spi_start/_data_tx/_cs - to SPI engine (CPU-driven once done)
//               spi_busy/spi_data_rx   - from SPI engine
//               cpu_spi_*             - CPU-side SPI controls (used when done)
//               mem_address/_data/_write_enable - RAM write port
//               load_count            - bytes loaded, in 256-byte pages
//               done/cpu_halt         - load complete / CPU stall (= ~done)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_loader #(
    parameter logic [23:0] FLASH_ADDR = 24'h020000,
    parameter int          LENGTH     = 4096,
    parameter logic [15:0] MEM_BASE   = 16'h0000,
    parameter int          CS_DELAY   = 4
) (
    input  logic        raw_clk,
    input  logic        reset,
    input  logic        reload,
    output logic        spi_start,
    output logic [7:0]  spi_data_tx,
    output logic        spi_cs,
    input  logic        spi_busy,
    input  logic [7:0]  spi_data_rx,
    input  logic        cpu_spi_start,
    input  logic [7:0]  cpu_spi_data_tx,
    input  logic        cpu_spi_cs,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data,
    output logic        mem_write_enable,
    output logic [7:0]  load_count,
    output logic        done,
    output logic        cpu_halt
);

    localparam logic [15:0] c_last_index = 16'(LENGTH - 1);
    localparam logic [7:0]  c_cs_last    = 8'(CS_DELAY - 1);
    localparam logic [7:0]  c_cmd_read   = 8'h03;

    typedef enum logic [3:0] {
        S_IDLE, S_CS_SETUP, S_CMD, S_A2, S_A1, S_A0,
        S_READ, S_WRMEM, S_CS_HOLD, S_DONE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_phase_wait, w_phase_wait_nxt;   // 0 = phase S, 1 = phase W
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [15:0] r_index, w_index_nxt;
    logic        r_start, w_start_nxt;
    logic [7:0]  r_tx, w_tx_nxt;
    logic        r_cs, w_cs_nxt;
    logic        r_we, w_we_nxt;
    logic [15:0] r_addr, w_addr_nxt;
    logic [7:0]  r_data, w_data_nxt;
    logic        r_done, w_done_nxt;

    logic        w_in_byte;
    logic        w_byte_done;

    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_phase_wait <= 1'b0;
            r_cnt        <= 8'd0;
            r_index      <= 16'd0;
            r_start      <= 1'b0;
            r_tx         <= 8'd0;
            r_cs         <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= 16'd0;
            r_data       <= 8'd0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase_wait <= w_phase_wait_nxt;
            r_cnt        <= w_cnt_nxt;
            r_index      <= w_index_nxt;
            r_start      <= w_start_nxt;
            r_tx         <= w_tx_nxt;
            r_cs         <= w_cs_nxt;
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_data       <= w_data_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign w_in_byte   = (r_state == S_CMD) || (r_state == S_A2) || (r_state == S_A1) ||
                         (r_state == S_A0)  || (r_state == S_READ);
    assign w_byte_done = w_in_byte && r_phase_wait && !spi_busy;

    always_comb begin
        w_state_nxt      = r_state;
        w_phase_wait_nxt = r_phase_wait;
        w_cnt_nxt        = r_cnt;
        w_index_nxt      = r_index;
        w_start_nxt      = r_start;
        w_tx_nxt         = r_tx;
        w_cs_nxt         = r_cs;
        w_we_nxt         = 1'b0;
        w_addr_nxt       = r_addr;
        w_data_nxt       = r_data;
        w_done_nxt       = r_done;

        // Phase S: keep start high until the engine acknowledges with busy.
        if (w_in_byte && !r_phase_wait && spi_busy) begin
            w_start_nxt      = 1'b0;
            w_phase_wait_nxt = 1'b1;
        end

        // Each byte_done branch below launches the next byte in phase S.
        unique case (r_state)
            S_IDLE: begin
                if (!spi_busy) begin
                    w_state_nxt = S_CS_SETUP;
                    w_cs_nxt    = 1'b0;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_CS_SETUP: begin
                if (r_cnt == c_cs_last) begin
                    w_state_nxt      = S_CMD;
                    w_start_nxt      = 1'b1;
                    w_tx_nxt         = c_cmd_read;
                    w_phase_wait_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_CMD, S_A2, S_A1, S_A0: begin
                if (w_byte_done) begin
                    w_start_nxt      = 1'b1;
                    w_phase_wait_nxt = 1'b0;
                    unique case (r_state)
                        S_CMD:   begin w_state_nxt = S_A2;   w_tx_nxt = FLASH_ADDR[23:16]; end
                        S_A2:    begin w_state_nxt = S_A1;   w_tx_nxt = FLASH_ADDR[15:8];  end
                        S_A1:    begin w_state_nxt = S_A0;   w_tx_nxt = FLASH_ADDR[7:0];   end
                        default: begin w_state_nxt = S_READ; w_tx_nxt = 8'h00;             end
                    endcase
                end
            end
            S_READ: begin
                // Strobe, data and address are registered on entry to WRMEM
                // so they are presented for exactly the WRMEM cycle.
                if (w_byte_done) begin
                    w_state_nxt = S_WRMEM;
                    w_we_nxt    = 1'b1;
                    w_data_nxt  = spi_data_rx;
                    w_addr_nxt  = MEM_BASE + r_index;
                end
            end
            S_WRMEM: begin
                w_index_nxt = r_index + 16'd1;
                if (r_index == c_last_index) begin
                    w_state_nxt = S_CS_HOLD;
                    w_cs_nxt    = 1'b1;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_state_nxt      = S_READ;
                    w_start_nxt      = 1'b1;
                    w_tx_nxt         = 8'h00;
                    w_phase_wait_nxt = 1'b0;
                end
            end
            S_CS_HOLD: begin
                if (r_cnt == 8'd1) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_DONE: begin
                if (reload) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b0;
                    w_cs_nxt    = 1'b1;
                    w_index_nxt = 16'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Once the load is complete the CPU owns the SPI engine outright.
    assign spi_start        = r_done ? cpu_spi_start   : r_start;
    assign spi_data_tx      = r_done ? cpu_spi_data_tx : r_tx;
    assign spi_cs           = r_done ? cpu_spi_cs      : r_cs;

    assign mem_address      = r_addr;
    assign mem_data         = r_data;
    assign mem_write_enable = r_we;
    assign load_count       = r_index[15:8];
    assign done             = r_done;
    assign cpu_halt         = ~r_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_loader
// Description : Scoreboard bench for spi_flash_loader with an 8-cycle SPI
//               engine model. LENGTH=600 at MEM_BASE=FFFE exercises page
//               counting and address wrap in one image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_loader;

    localparam int          LEN   = 600;
    localparam logic [15:0] BASE  = 16'hFFFE;
    localparam int          NBUSY = 8;

    logic        raw_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        reload  = 1'b0;
    logic        spi_start;
    logic [7:0]  spi_data_tx;
    logic        spi_cs;
    logic        spi_busy    = 1'b0;
    logic [7:0]  spi_data_rx = 8'h00;
    logic        cpu_spi_start   = 1'b0;
    logic [7:0]  cpu_spi_data_tx = 8'h00;
    logic        cpu_spi_cs      = 1'b1;
    logic [15:0] mem_address;
    logic [7:0]  mem_data;
    logic        mem_write_enable;
    logic [7:0]  load_count;
    logic        done;
    logic        cpu_halt;

    always #5 raw_clk = ~raw_clk;

    spi_flash_loader #(
        .FLASH_ADDR (24'h020000),
        .LENGTH     (LEN),
        .MEM_BASE   (BASE),
        .CS_DELAY   (4)
    ) dut (
        .raw_clk          (raw_clk),
        .reset            (reset),
        .reload           (reload),
        .spi_start        (spi_start),
        .spi_data_tx      (spi_data_tx),
        .spi_cs           (spi_cs),
        .spi_busy         (spi_busy),
        .spi_data_rx      (spi_data_rx),
        .cpu_spi_start    (cpu_spi_start),
        .cpu_spi_data_tx  (cpu_spi_data_tx),
        .cpu_spi_cs       (cpu_spi_cs),
        .mem_address      (mem_address),
        .mem_data         (mem_data),
        .mem_write_enable (mem_write_enable),
        .load_count       (load_count),
        .done             (done),
        .cpu_halt         (cpu_halt)
    );

    // Flash image content: first four bytes are hand-picked, rest a simple ramp.
    function automatic logic [7:0] rx_pat(input int k);
        case (k)
            0:       return 8'hA5;
            1:       return 8'h5A;
            2:       return 8'hFF;
            3:       return 8'h00;
            default: return 8'((k * 37 + 11) & 255);
        endcase
    endfunction

    // ---------------- SPI engine model ----------------
    int         eng_cnt  = 0;
    int         xfer_cnt = 0;
    logic [7:0] eng_rx   = 8'h00;

    always @(posedge raw_clk) begin
        if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                spi_busy    <= 1'b0;
                spi_data_rx <= eng_rx;
            end
        end else if (spi_start) begin
            spi_busy <= 1'b1;
            eng_cnt  <= NBUSY;
            eng_rx   <= (!done && xfer_cnt >= 4) ? rx_pat(xfer_cnt - 4) : 8'hEE;
        end
        if (!done && spi_cs)
            xfer_cnt <= 0;
        else if (!done && eng_cnt == 0 && spi_start)
            xfer_cnt <= xfer_cnt + 1;
    end

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  tx_q[$];
    logic [31:0] wr_q[$];   // {load_count, address, data}
    int          tx_total = 0;
    int          wr_total = 0;
    logic        prev_cs   = 1'b1;
    logic        prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_load();
        tx_q.delete();
        wr_q.delete();
        tx_q.push_back(8'h03);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        for (int k = 0; k < LEN; k++) begin
            tx_q.push_back(8'h00);
            wr_q.push_back({8'(k >> 8), BASE + 16'(k), rx_pat(k)});
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge raw_clk) begin
        logic [7:0]  t;
        logic [31:0] w;
        if (reset && !done && spi_start && !spi_busy) begin
            tx_total++;
            check("tx_cs_low", 32'(spi_cs), 32'(0));
            if (tx_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tx_unexpected: got byte %0h, expected no transfer", spi_data_tx);
            end else begin
                t = tx_q.pop_front();
                check("tx_byte", 32'(spi_data_tx), 32'(t));
            end
        end
        if (mem_write_enable) begin
            wr_total++;
            if (wr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: got write to %0h, expected none", mem_address);
            end else begin
                w = wr_q.pop_front();
                check("wr_addr", 32'(mem_address), 32'(w[23:8]));
                check("wr_data", 32'(mem_data), 32'(w[7:0]));
                check("wr_load_count", 32'(load_count), 32'(w[31:24]));
                check("wr_cs_low", 32'(spi_cs), 32'(0));
            end
        end
        if (done && !prev_done)
            check("cs_high_before_done", 32'(prev_cs), 32'(1));
        prev_cs   = spi_cs;
        prev_done = done;
    end

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 20000) begin
            @(negedge raw_clk);
            n++;
        end
        check(name, 32'(done), 32'(1));
    endtask

    task automatic check_end();
        check("tx_queue_drained", 32'(tx_q.size()), 32'(0));
        check("wr_queue_drained", 32'(wr_q.size()), 32'(0));
        check("final_load_count", 32'(load_count), 32'(LEN >> 8));
        check("cpu_halt_released", 32'(cpu_halt), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int n;
        logic ok;

        #2 reset = 1'b0;
        repeat (3) @(negedge raw_clk);
        check("rst_cs", 32'(spi_cs), 32'(1));
        check("rst_start", 32'(spi_start), 32'(0));
        check("rst_tx", 32'(spi_data_tx), 32'(0));
        check("rst_we", 32'(mem_write_enable), 32'(0));
        check("rst_addr", 32'(mem_address), 32'(0));
        check("rst_data", 32'(mem_data), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_halt", 32'(cpu_halt), 32'(1));
        check("rst_load_count", 32'(load_count), 32'(0));

        // First load; a reload pulse mid-load must be ignored.
        push_load();
        reset = 1'b1;
        n = 0;
        while (wr_total < 10 && n < 2000) begin
            @(negedge raw_clk);
            n++;
        end
        check("load1_progress", 32'(wr_total >= 10), 32'(1));
        reload = 1'b1;
        @(negedge raw_clk);
        reload = 1'b0;
        wait_done("load1_done");
        check_end();

        // CPU pass-through once done.
        cpu_spi_cs      = 1'b0;
        cpu_spi_data_tx = 8'hC3;
        cpu_spi_start   = 1'b1;
        #1;
        check("cpu_cs_mux", 32'(spi_cs), 32'(0));
        check("cpu_tx_mux", 32'(spi_data_tx), 32'(8'hC3));
        check("cpu_start_mux", 32'(spi_start), 32'(1));
        cpu_spi_cs = 1'b1;
        #1;
        check("cpu_cs_mux_follow", 32'(spi_cs), 32'(1));
        cpu_spi_cs = 1'b0;
        @(negedge raw_clk);
        cpu_spi_start = 1'b0;
        check("cpu_xfer_busy", 32'(spi_busy), 32'(1));

        // Reload while the CPU transfer is still in flight.
        push_load();
        reload = 1'b1;
        @(negedge raw_clk);
        reload = 1'b0;
        check("reload_done_low", 32'(done), 32'(0));
        check("reload_halt", 32'(cpu_halt), 32'(1));
        check("reload_load_count", 32'(load_count), 32'(0));
        ok = 1'b1;
        n  = 0;
        while (spi_busy && n < 50) begin
            if (spi_start !== 1'b0 || spi_cs !== 1'b1) ok = 1'b0;
            @(negedge raw_clk);
            n++;
        end
        check("idle_waits_cpu_busy", 32'(ok), 32'(1));
        check("cpu_xfer_finished", 32'(spi_busy), 32'(0));
        cpu_spi_cs      = 1'b1;
        cpu_spi_data_tx = 8'h00;
        wait_done("load2_done");
        check_end();

        // Reset during the second READ byte, then a clean restart.
        push_load();
        base = tx_total;
        reload = 1'b1;
        @(negedge raw_clk);
        reload = 1'b0;
        n = 0;
        while (tx_total - base < 6 && n < 2000) begin
            @(negedge raw_clk);
            n++;
        end
        check("reach_read_byte2", 32'(tx_total - base), 32'(6));
        repeat (3) @(posedge raw_clk);
        #2 reset = 1'b0;
        #1;
        check("async_cs_high", 32'(spi_cs), 32'(1));
        check("async_done_low", 32'(done), 32'(0));
        check("async_index_clear", 32'(load_count), 32'(0));
        repeat (2) @(negedge raw_clk);
        push_load();
        reset = 1'b1;
        wait_done("load3_done");
        check_end();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
